// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer bank.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_LOAD,
    CMD_START,
    CMD_PAUSE
  } timer_cmd_t;

  localparam int SEC_MAX = 59;

endpackage

// File: rtl/countdown_channel.sv
// One MM:SS countdown channel: command execution, 1 Hz countdown, expiry and alarm latch.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | loaded or cleared, not counting
// RUN     | counting down one second per clk1hz edge
// PAUSED  | counting suspended, value held
// EXPIRED | one-shot expiry reached, holding 00:00 until load/start/clear
module countdown_channel
  import timer_pkg::*;
#(
  parameter int MIN_W   = 7,
  parameter int SEC_W   = 6,
  parameter int MAX_MIN = 99
) (
  input  logic               clk1hz,
  input  logic               reset,
  input  timer_cmd_t         cmd,
  input  logic [MIN_W-1:0]   new_min,
  input  logic [SEC_W-1:0]   new_sec,
  input  logic               auto_reload,
  input  logic               alarm_ack,
  output timer_state_t       state,
  output logic [MIN_W-1:0]   cur_min,
  output logic [SEC_W-1:0]   cur_sec,
  output logic               expired,
  output logic               alarm_pulse,
  output logic               reject
);

  timer_state_t       state_n;
  logic [MIN_W-1:0]   cur_min_n, rld_min, rld_min_n;
  logic [SEC_W-1:0]   cur_sec_n, rld_sec, rld_sec_n;
  logic               expired_n, alarm_pulse_n;
  logic               cur_zero, rld_zero, load_bad;

  assign cur_zero = (cur_min == '0) && (cur_sec == '0);
  assign rld_zero = (rld_min == '0) && (rld_sec == '0);
  assign load_bad = (new_sec > SEC_W'(SEC_MAX)) || (new_min > MIN_W'(MAX_MIN));

  // State and value registers; reset returns the channel to IDLE at 00:00.
  always_ff @(posedge clk1hz) begin
    if (reset) begin
      state       <= IDLE;
      cur_min     <= '0;
      cur_sec     <= '0;
      rld_min     <= '0;
      rld_sec     <= '0;
      expired     <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      cur_min     <= cur_min_n;
      cur_sec     <= cur_sec_n;
      rld_min     <= rld_min_n;
      rld_sec     <= rld_sec_n;
      expired     <= expired_n;
      alarm_pulse <= alarm_pulse_n;
    end
  end

  // Next-state: any command on this channel replaces the countdown step for that cycle.
  always_comb begin
    state_n       = state;
    cur_min_n     = cur_min;
    cur_sec_n     = cur_sec;
    rld_min_n     = rld_min;
    rld_sec_n     = rld_sec;
    expired_n     = expired;
    alarm_pulse_n = 1'b0;
    reject        = 1'b0;

    // Ack first so a same-cycle expiry below sets the flag again.
    if (alarm_ack) expired_n = 1'b0;

    case (cmd)
      CMD_CLEAR: begin
        state_n   = IDLE;
        cur_min_n = '0;
        cur_sec_n = '0;
        rld_min_n = '0;
        rld_sec_n = '0;
        expired_n = 1'b0;
      end
      CMD_LOAD: begin
        if (load_bad || (state == RUN)) begin
          reject = 1'b1;
        end else begin
          state_n   = IDLE;
          cur_min_n = new_min;
          cur_sec_n = new_sec;
          rld_min_n = new_min;
          rld_sec_n = new_sec;
          expired_n = 1'b0;
        end
      end
      CMD_START: begin
        case (state)
          IDLE, PAUSED: begin
            if (cur_zero) reject = 1'b1;
            else          state_n = RUN;
          end
          EXPIRED: begin
            if (rld_zero) begin
              reject = 1'b1;
            end else begin
              state_n   = RUN;
              cur_min_n = rld_min;
              cur_sec_n = rld_sec;
              expired_n = 1'b0;
            end
          end
          default: ;
        endcase
      end
      CMD_PAUSE: begin
        if (state == RUN) state_n = PAUSED;
      end
      default: begin
        if (state == RUN) begin
          if (cur_sec != '0) begin
            cur_sec_n = cur_sec - SEC_W'(1);
          end else if (cur_min != '0) begin
            cur_min_n = cur_min - MIN_W'(1);
            cur_sec_n = SEC_W'(SEC_MAX);
          end else begin
            // 00:00 has been shown for one cycle; expire now.
            alarm_pulse_n = 1'b1;
            expired_n     = 1'b1;
            if (auto_reload) begin
              cur_min_n = rld_min;
              cur_sec_n = rld_sec;
            end else begin
              state_n = EXPIRED;
            end
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of independent MM:SS countdown timers with shared command strobes.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MIN_W   = 7,
  parameter int MAX_MIN = 99,
  parameter int SEC_W   = 6,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk1hz,
  input  logic                    reset,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic                    load,
  input  logic [MIN_W-1:0]        new_min,
  input  logic [SEC_W-1:0]        new_sec,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH-1:0]       alarm_ack,
  output logic                    cmd_err,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH-1:0]       alarm_pulse,
  output logic [NUM_CH*MIN_W-1:0] min_out,
  output logic [NUM_CH*SEC_W-1:0] sec_out
);

  timer_cmd_t        cmd_sel;
  logic              any_strobe;
  logic              sel_bad;
  logic [NUM_CH-1:0] ch_reject;

  assign any_strobe = clear | load | start | pause;
  assign sel_bad    = ({1'b0, ch_sel} >= (CH_W+1)'(NUM_CH));

  // Strobe priority decode: clear > load > start > pause.
  always_comb begin
    cmd_sel = CMD_NONE;
    if (clear)      cmd_sel = CMD_CLEAR;
    else if (load)  cmd_sel = CMD_LOAD;
    else if (start) cmd_sel = CMD_START;
    else if (pause) cmd_sel = CMD_PAUSE;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_cmd_t   ch_cmd;
    timer_state_t ch_state;

    assign ch_cmd = (!sel_bad && (ch_sel == CH_W'(i))) ? cmd_sel : CMD_NONE;

    countdown_channel #(
      .MIN_W   (MIN_W),
      .SEC_W   (SEC_W),
      .MAX_MIN (MAX_MIN)
    ) u_ch (
      .clk1hz      (clk1hz),
      .reset       (reset),
      .cmd         (ch_cmd),
      .new_min     (new_min),
      .new_sec     (new_sec),
      .auto_reload (auto_reload[i]),
      .alarm_ack   (alarm_ack[i]),
      .state       (ch_state),
      .cur_min     (min_out[i*MIN_W +: MIN_W]),
      .cur_sec     (sec_out[i*SEC_W +: SEC_W]),
      .expired     (expired[i]),
      .alarm_pulse (alarm_pulse[i]),
      .reject      (ch_reject[i])
    );

    assign running[i] = (ch_state == RUN);
  end

  // One-cycle error pulse for a rejected command or an out-of-range channel.
  always_ff @(posedge clk1hz) begin
    if (reset) cmd_err <= 1'b0;
    else       cmd_err <= (any_strobe && sel_bad) || (|ch_reject);
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed test-plan sequences plus random stimulus against a seconds-based reference model.
module tb_countdown_timer_bank;

  localparam int NCH  = 5;
  localparam int MW   = 7;
  localparam int SW   = 6;
  localparam int MAXM = 99;
  localparam int CW   = 3;

  localparam int K_CLEAR = 1, K_LOAD = 2, K_START = 3, K_PAUSE = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic              clk1hz;
  logic              reset;
  logic [CW-1:0]     ch_sel;
  logic              load, start, pause, clear;
  logic [MW-1:0]     new_min;
  logic [SW-1:0]     new_sec;
  logic [NCH-1:0]    auto_reload, alarm_ack;
  logic              cmd_err;
  logic [NCH-1:0]    running, expired, alarm_pulse;
  logic [NCH*MW-1:0] min_out;
  logic [NCH*SW-1:0] sec_out;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: each channel's value kept as total seconds
  int m_t [NCH];
  int m_r [NCH];
  int m_st[NCH];
  bit m_exp[NCH];
  bit m_pulse[NCH];
  bit m_err;

  countdown_timer_bank #(.NUM_CH(NCH), .MIN_W(MW), .MAX_MIN(MAXM), .SEC_W(SW)) dut (
    .clk1hz      (clk1hz),
    .reset       (reset),
    .ch_sel      (ch_sel),
    .load        (load),
    .new_min     (new_min),
    .new_sec     (new_sec),
    .start       (start),
    .pause       (pause),
    .clear       (clear),
    .auto_reload (auto_reload),
    .alarm_ack   (alarm_ack),
    .cmd_err     (cmd_err),
    .running     (running),
    .expired     (expired),
    .alarm_pulse (alarm_pulse),
    .min_out     (min_out),
    .sec_out     (sec_out)
  );

  initial clk1hz = 1'b0;
  always #5 clk1hz = ~clk1hz;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int dsec(input int i);
    return int'(sec_out[i*SW +: SW]);
  endfunction

  function automatic int dmin(input int i);
    return int'(min_out[i*MW +: MW]);
  endfunction

  task automatic model_step();
    bit any, mine;
    any   = load | start | pause | clear;
    m_err = 1'b0;
    for (int i = 0; i < NCH; i++) m_pulse[i] = 1'b0;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_t[i] = 0; m_r[i] = 0; m_st[i] = M_IDLE; m_exp[i] = 1'b0;
      end
      return;
    end
    if (any && int'(ch_sel) >= NCH) m_err = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      mine = any && (int'(ch_sel) == i);
      if (alarm_ack[i]) m_exp[i] = 1'b0;
      if (mine) begin
        if (clear) begin
          m_t[i] = 0; m_r[i] = 0; m_st[i] = M_IDLE; m_exp[i] = 1'b0;
        end else if (load) begin
          if (int'(new_sec) > 59 || int'(new_min) > MAXM || m_st[i] == M_RUN) m_err = 1'b1;
          else begin
            m_t[i] = int'(new_min) * 60 + int'(new_sec);
            m_r[i] = m_t[i]; m_exp[i] = 1'b0; m_st[i] = M_IDLE;
          end
        end else if (start) begin
          if (m_st[i] == M_EXP) begin
            if (m_r[i] == 0) m_err = 1'b1;
            else begin m_t[i] = m_r[i]; m_exp[i] = 1'b0; m_st[i] = M_RUN; end
          end else if (m_st[i] != M_RUN) begin
            if (m_t[i] == 0) m_err = 1'b1;
            else m_st[i] = M_RUN;
          end
        end else if (pause && m_st[i] == M_RUN) begin
          m_st[i] = M_PAUSED;
        end
      end else if (m_st[i] == M_RUN) begin
        if (m_t[i] > 0) m_t[i]--;
        else begin
          m_pulse[i] = 1'b1; m_exp[i] = 1'b1;
          if (auto_reload[i]) m_t[i] = m_r[i];
          else m_st[i] = M_EXP;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] e_min, e_sec, e_run, e_exp, e_pul;
    e_min = '0; e_sec = '0; e_run = '0; e_exp = '0; e_pul = '0;
    for (int i = 0; i < NCH; i++) begin
      e_min[i*MW +: MW] = MW'(m_t[i] / 60);
      e_sec[i*SW +: SW] = SW'(m_t[i] % 60);
      e_run[i] = (m_st[i] == M_RUN);
      e_exp[i] = m_exp[i];
      e_pul[i] = m_pulse[i];
    end
    chk("cmd_err", 64'(cmd_err), 64'(m_err));
    chk("running", 64'(running), e_run);
    chk("expired", 64'(expired), e_exp);
    chk("alarm_pulse", 64'(alarm_pulse), e_pul);
    chk("min_out", 64'(min_out), e_min);
    chk("sec_out", 64'(sec_out), e_sec);
  endtask

  // one clock: model follows the edge, outputs compared shortly after, return at negedge
  task automatic tick();
    @(posedge clk1hz);
    model_step();
    #1;
    compare_all();
    @(negedge clk1hz);
  endtask

  task automatic cmd(input int kind, input int ch, input int mn = 0, input int sc = 0);
    ch_sel  = CW'(ch);
    new_min = MW'(mn);
    new_sec = SW'(sc);
    clear   = (kind == K_CLEAR);
    load    = (kind == K_LOAD);
    start   = (kind == K_START);
    pause   = (kind == K_PAUSE);
    tick();
    {clear, load, start, pause} = 4'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_t[i] = 0; m_r[i] = 0; m_st[i] = M_IDLE; m_exp[i] = 1'b0; m_pulse[i] = 1'b0;
    end
    m_err = 1'b0;
    reset = 1'b1; ch_sel = '0; load = 0; start = 0; pause = 0; clear = 0;
    new_min = '0; new_sec = '0; auto_reload = '0; alarm_ack = '0;
    tick(); tick();
    chk("rst_min", 64'(min_out), 64'd0);
    chk("rst_run", 64'(running), 64'd0);
    reset = 1'b0;

    // load and run
    cmd(K_LOAD, 0, 0, 3);
    cmd(K_START, 0);
    tick(); chk("lr_s2", dsec(0), 2);
    tick(); chk("lr_s1", dsec(0), 1);
    tick(); chk("lr_s0", dsec(0), 0); chk("lr_run", running[0], 1);
    tick(); chk("lr_pulse", alarm_pulse[0], 1); chk("lr_exp", expired[0], 1);
    chk("lr_stop", running[0], 0);
    tick(); chk("lr_pulse1", alarm_pulse[0], 0); chk("lr_hold", dsec(0), 0);
    alarm_ack[0] = 1'b1; tick(); alarm_ack[0] = 1'b0;
    chk("lr_ack", expired[0], 0);

    // minute borrow and pause
    cmd(K_LOAD, 1, 1, 0);
    cmd(K_START, 1);
    tick(); chk("mb_min", dmin(1), 0); chk("mb_sec", dsec(1), 59);
    tick(); tick(); chk("mb_57", dsec(1), 57);
    cmd(K_PAUSE, 1);
    repeat (5) tick();
    chk("mb_held", dsec(1), 57);
    cmd(K_START, 1);
    tick(); chk("mb_resume", dsec(1), 56);

    // auto-reload
    auto_reload[2] = 1'b1;
    cmd(K_LOAD, 2, 0, 2);
    cmd(K_START, 2);
    tick(); chk("ar_s1", dsec(2), 1);
    tick(); chk("ar_s0", dsec(2), 0);
    tick(); chk("ar_pulse", alarm_pulse[2], 1); chk("ar_rld", dsec(2), 2);
    chk("ar_run", running[2], 1);
    tick(); tick();
    alarm_ack[2] = 1'b1; tick(); alarm_ack[2] = 1'b0;
    chk("ar_ackset", expired[2], 1); chk("ar_pulse2", alarm_pulse[2], 1);

    // rejections
    cmd(K_LOAD, 0, 0, 60);      chk("rj_sec", cmd_err, 1);
    cmd(K_LOAD, 0, MAXM + 1, 0); chk("rj_min", cmd_err, 1);
    cmd(K_LOAD, 1, 0, 5);       chk("rj_run", cmd_err, 1);
    cmd(K_START, 4);            chk("rj_zero", cmd_err, 1);
    cmd(K_START, NCH);          chk("rj_sel", cmd_err, 1);
    tick();                     chk("rj_clr", cmd_err, 0);

    // priority: clear wins over load and start
    cmd(K_LOAD, 3, 0, 5);
    cmd(K_START, 3);
    tick();
    ch_sel = 3'd3; new_min = 7'd0; new_sec = 6'd9;
    clear = 1'b1; load = 1'b1; start = 1'b1;
    tick();
    {clear, load, start, pause} = 4'b0;
    chk("pr_run", running[3], 0); chk("pr_sec", dsec(3), 0);

    // reset mid-run on all channels
    cmd(K_LOAD, 0, 0, 40); cmd(K_START, 0);
    cmd(K_LOAD, 3, 0, 40); cmd(K_START, 3);
    cmd(K_LOAD, 4, 1, 5);  cmd(K_START, 4);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rs_run", 64'(running), 64'd0); chk("rs_sec", 64'(sec_out), 64'd0);
    repeat (3) tick();
    chk("rs_stay", 64'(running), 64'd0);

    // random phase
    auto_reload = '0;
    repeat (4000) begin
      reset   = ($urandom_range(0, 999) < 3);
      ch_sel  = CW'($urandom_range(0, NCH + 1));
      clear   = ($urandom_range(0, 99) < 3);
      load    = ($urandom_range(0, 99) < 8);
      start   = ($urandom_range(0, 99) < 10);
      pause   = ($urandom_range(0, 99) < 4);
      new_min = ($urandom_range(0, 9) == 0) ? MW'($urandom_range(0, MAXM + 2))
                                            : MW'($urandom_range(0, 1));
      new_sec = SW'($urandom_range(0, 62));
      for (int i = 0; i < NCH; i++) begin
        alarm_ack[i] = ($urandom_range(0, 99) < 5);
        if ($urandom_range(0, 99) < 2) auto_reload[i] = ~auto_reload[i];
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
